// File: rtl/wave_sweep_controller.sv
// Steps wave_generator through a phase-increment sweep; optional SWEEP_STATUS_EN adds step_cnt_o.
// Strobes are one cycle each. Phase loads are spaced DWELL sample strobes + 2 cycles. Config writes are accepted only in IDLE.
module wave_sweep_controller #(
    parameter int DATA_W  = 8,
    parameter int DWELL_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [2:0]        cfg_addr_i,
    input  logic [DATA_W-1:0] cfg_data_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              sample_strobe_i,
    output logic              enable_o,
    output logic [1:0]        waveform_o,
    output logic              set_amplitude_strobe_o,
    output logic              set_phase_strobe_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              done_o
`ifdef SWEEP_STATUS_EN
    ,
    output logic [7:0]        step_cnt_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_AMP,
        S_LOAD_PHASE,
        S_DWELL,
        S_STEP,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_start;
    logic [DATA_W-1:0]   r_stop;
    logic [DATA_W-1:0]   r_step;
    logic [DWELL_W-1:0]  r_dwell;
    logic [DATA_W-1:0]   r_ampl;
    logic [3:0]          r_mode;
    logic [DATA_W-1:0]   r_cur;
    logic [DWELL_W-1:0]  r_cnt;
    logic [1:0]          r_waveform;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W:0]     w_nxt;
    logic                w_end;
    logic                w_go;

    // Extra top bit holds the carry (up) or borrow (down) that ends a sweep.
    assign w_sum  = {1'b0, r_cur} + {1'b0, r_step};
    assign w_diff = {1'b0, r_cur} - {1'b0, r_step};
    assign w_nxt  = r_mode[1] ? w_diff : w_sum;
    assign w_end  = w_nxt[DATA_W] ||
                    (r_mode[1] ? (w_nxt[DATA_W-1:0] < r_stop) : (w_nxt[DATA_W-1:0] > r_stop));
    assign w_go   = start_i && !abort_i && (r_step != '0);
    assign waveform_o = r_waveform;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt            = r_state;
        cfg_ready_o            = 1'b0;
        enable_o               = 1'b0;
        set_amplitude_strobe_o = 1'b0;
        set_phase_strobe_o     = 1'b0;
        data_o                 = '0;
        busy_o                 = 1'b1;
        done_o                 = 1'b0;
        case (r_state)
            S_IDLE: begin
                cfg_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (w_go) w_state_nxt = S_LOAD_AMP;
            end
            S_LOAD_AMP: begin
                set_amplitude_strobe_o = 1'b1;
                data_o                 = r_ampl;
                w_state_nxt            = S_LOAD_PHASE;
            end
            S_LOAD_PHASE: begin
                set_phase_strobe_o = 1'b1;
                enable_o           = 1'b1;
                data_o             = r_cur;
                w_state_nxt        = S_DWELL;
            end
            S_DWELL: begin
                enable_o = 1'b1;
                if (sample_strobe_i && (r_cnt == DWELL_W'(1))) w_state_nxt = S_STEP;
            end
            S_STEP: begin
                enable_o    = 1'b1;
                w_state_nxt = (w_end && !r_mode[0]) ? S_DONE : S_LOAD_PHASE;
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort_i) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_start    <= '0;
            r_stop     <= '1;
            r_step     <= DATA_W'(1);
            r_dwell    <= DWELL_W'(1);
            r_ampl     <= '1;
            r_mode     <= '0;
            r_cur      <= '0;
            r_cnt      <= '0;
            r_waveform <= '0;
        end else begin
            r_waveform <= r_mode[3:2];
            if (cfg_valid_i && (r_state == S_IDLE)) begin
                case (cfg_addr_i)
                    3'd0:    r_start <= cfg_data_i;
                    3'd1:    r_stop  <= cfg_data_i;
                    3'd2:    r_step  <= cfg_data_i;
                    3'd3:    r_dwell <= DWELL_W'(cfg_data_i);
                    3'd4:    r_ampl  <= cfg_data_i;
                    3'd5:    r_mode  <= cfg_data_i[3:0];
                    default: ;
                endcase
            end
            case (r_state)
                S_IDLE:       if (w_go) r_cur <= r_start;
                S_LOAD_PHASE: r_cnt <= (r_dwell == '0) ? DWELL_W'(1) : r_dwell;
                S_DWELL:      if (sample_strobe_i && (r_cnt != DWELL_W'(1))) r_cnt <= r_cnt - DWELL_W'(1);
                S_STEP:       r_cur <= w_end ? r_start : w_nxt[DATA_W-1:0];
                default:      ;
            endcase
        end
    end

`ifdef SWEEP_STATUS_EN
    logic [7:0] r_step_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_step_cnt <= '0;
        end else if ((r_state == S_IDLE) && w_go) begin
            r_step_cnt <= '0;
        end else if ((r_state == S_LOAD_PHASE) && (r_step_cnt != 8'hFF)) begin
            r_step_cnt <= r_step_cnt + 8'd1;
        end
    end

    assign step_cnt_o = r_step_cnt;
`endif

endmodule

// File: tb/tb_wave_sweep_controller.sv
// Directed-plus-random bench for wave_sweep_controller; expected phase sequences come from a list model.
module tb_wave_sweep_controller;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       cfg_valid_i;
    logic       cfg_ready_o;
    logic [2:0] cfg_addr_i;
    logic [7:0] cfg_data_i;
    logic       start_i;
    logic       abort_i;
    logic       sample_strobe_i;
    logic       enable_o;
    logic [1:0] waveform_o;
    logic       set_amplitude_strobe_o;
    logic       set_phase_strobe_o;
    logic [7:0] data_o;
    logic       busy_o;
    logic       done_o;
`ifdef SWEEP_STATUS_EN
    logic [7:0] step_cnt_o;
`endif

    wave_sweep_controller #(.DATA_W(8), .DWELL_W(8)) dut (
        .clk_i                  (clk),
        .rst_i                  (rst_i),
        .cfg_valid_i            (cfg_valid_i),
        .cfg_ready_o            (cfg_ready_o),
        .cfg_addr_i             (cfg_addr_i),
        .cfg_data_i             (cfg_data_i),
        .start_i                (start_i),
        .abort_i                (abort_i),
        .sample_strobe_i        (sample_strobe_i),
        .enable_o               (enable_o),
        .waveform_o             (waveform_o),
        .set_amplitude_strobe_o (set_amplitude_strobe_o),
        .set_phase_strobe_o     (set_phase_strobe_o),
        .data_o                 (data_o),
        .busy_o                 (busy_o),
        .done_o                 (done_o)
`ifdef SWEEP_STATUS_EN
        ,
        .step_cnt_o             (step_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int obs_loads[$];
    int obs_amps[$];
    int obs_done;
    int dwell_err;
    int en_err;
    int wf_err;
    int rdy_err;
    bit timed_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: list of phase values a non-looping sweep must load.
    function automatic void build(input int st, input int sp, input int stp, input bit dn);
        int v;
        exp_q.delete();
        v = st;
        do begin
            exp_q.push_back(v);
            v = dn ? v - stp : v + stp;
        end while (v >= 0 && v <= 255 && (dn ? v >= sp : v <= sp));
    endfunction

    task automatic chk_loads(input string tag);
        chk({tag, "_count"}, obs_loads.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_loads.size(); i++)
            chk({tag, "_val"}, obs_loads[i], exp_q[i]);
    endtask

    task automatic cfg(input int addr, input int data);
        @(negedge clk);
        cfg_valid_i = 1'b1;
        cfg_addr_i  = 3'(addr);
        cfg_data_i  = 8'(data);
        @(negedge clk);
        cfg_valid_i = 1'b0;
    endtask

    // Starts a sweep, drives random strobes (never back-to-back) and records everything seen.
    task automatic sweep(input int exp_dwell, input int abort_after, input int exp_wf, input bit mid_write);
        int since = 0;
        int last_sc = -100;
        int gap = 0;
        bit seen_busy = 0;
        bit pl;
        obs_loads.delete();
        obs_amps.delete();
        obs_done = 0; dwell_err = 0; en_err = 0; wf_err = 0; rdy_err = 0;
        timed_out = 1;
        @(negedge clk);
        start_i = 1'b1;
        sample_strobe_i = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            start_i = 1'b0; abort_i = 1'b0; cfg_valid_i = 1'b0;
            if (busy_o) seen_busy = 1;
            if (seen_busy && !busy_o) begin
                timed_out = 0;
                break;
            end
            if (set_amplitude_strobe_o) obs_amps.push_back(int'(data_o));
            pl = set_phase_strobe_o;
            if (pl) begin
                if (obs_loads.size() > 0 && (since != exp_dwell || cyc - last_sc != 2)) dwell_err++;
                obs_loads.push_back(int'(data_o));
            end
            if (done_o) obs_done++;
            if (set_phase_strobe_o && !enable_o) en_err++;
            if ((set_amplitude_strobe_o || done_o) && enable_o) en_err++;
            if (waveform_o != 2'(exp_wf)) wf_err++;
            if (mid_write && pl && obs_loads.size() == 1) begin
                if (cfg_ready_o) rdy_err++;
                cfg_valid_i = 1'b1; cfg_addr_i = 3'd4; cfg_data_i = 8'd7;
            end
            if (abort_after > 0 && pl && obs_loads.size() == abort_after) abort_i = 1'b1;
            sample_strobe_i = 1'b0;
            if (gap == 0) begin
                sample_strobe_i = 1'b1;
                since++;
                last_sc = cyc;
                gap = $urandom_range(1, 4);
            end else begin
                gap--;
            end
            if (pl) since = 0;
        end
        sample_strobe_i = 1'b0;
        chk("timeout", timed_out, 0);
        chk("dwell_spacing", dwell_err, 0);
        chk("enable", en_err, 0);
        chk("waveform", wf_err, 0);
    endtask

    initial begin
        rst_i = 1'b0; cfg_valid_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
        start_i = 1'b0; abort_i = 1'b0; sample_strobe_i = 1'b0;
        #22;
        chk("rst_ready", cfg_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_enable", enable_o, 0);
        chk("rst_strobes", {set_amplitude_strobe_o, set_phase_strobe_o, done_o}, 0);
        chk("rst_data", data_o, 0);
        chk("rst_waveform", waveform_o, 0);
        @(negedge clk);
        rst_i = 1'b1;

        // Up sweep 10..30 by 10, with an AMPL write attempted mid-sweep.
        cfg(0, 10); cfg(1, 30); cfg(2, 10); cfg(3, 2); cfg(5, 0);
        build(10, 30, 10, 0);
        sweep(2, 0, 0, 1);
        chk_loads("up");
        chk("up_amp_count", obs_amps.size(), 1);
        if (obs_amps.size() > 0) chk("up_amp_val", obs_amps[0], 255);
        chk("up_done", obs_done, 1);
        chk("busy_write_ready", rdy_err, 0);
`ifdef SWEEP_STATUS_EN
        chk("up_step_cnt", step_cnt_o, 3);
`endif

        // Down sweep; AMPL must still be 255 since the busy write was refused.
        cfg(0, 30); cfg(1, 10); cfg(5, 2);
        build(30, 10, 10, 1);
        sweep(2, 0, 0, 0);
        chk_loads("down");
        if (obs_amps.size() > 0) chk("down_amp_val", obs_amps[0], 255);
        chk("down_done", obs_done, 1);

        // Overflow ends after a single load.
        cfg(0, 250); cfg(1, 255); cfg(5, 0);
        build(250, 255, 10, 0);
        sweep(2, 0, 0, 0);
        chk_loads("ovf");
        chk("ovf_done", obs_done, 1);

        // Loop with DWELL=0 behaving as 1; abort after five loads.
        cfg(0, 0); cfg(1, 5); cfg(2, 5); cfg(3, 0); cfg(5, 1);
        exp_q = '{0, 5, 0, 5, 0};
        sweep(1, 5, 0, 0);
        chk_loads("loop");
        chk("loop_abort_done", obs_done, 0);
        chk("loop_abort_enable", enable_o, 0);
`ifdef SWEEP_STATUS_EN
        chk("loop_step_cnt", step_cnt_o, 5);
`endif

        // Abort wins over start; STEP=0 blocks start.
        @(negedge clk);
        start_i = 1'b1; abort_i = 1'b1;
        @(negedge clk);
        chk("abort_beats_start", busy_o, 0);
        start_i = 1'b0; abort_i = 1'b0;
        cfg(2, 0);
        @(negedge clk);
        start_i = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("step0_busy", busy_o, 0);
        chk("step0_ready", cfg_ready_o, 1);
        start_i = 1'b0;

        // Random non-looping sweeps against the list model.
        for (int it = 0; it < 4; it++) begin
            int st, sp, stp, dw, am, wf;
            bit dn;
            st = $urandom_range(0, 255); sp = $urandom_range(0, 255); stp = $urandom_range(16, 96);
            dn = 1'($urandom_range(0, 1)); dw = $urandom_range(0, 3);
            am = $urandom_range(0, 255); wf = $urandom_range(0, 3);
            cfg(0, st); cfg(1, sp); cfg(2, stp); cfg(3, dw); cfg(4, am); cfg(5, (wf << 2) | (int'(dn) << 1));
            build(st, sp, stp, dn);
            sweep(dw == 0 ? 1 : dw, 0, wf, 0);
            chk_loads("rand");
            if (obs_amps.size() > 0) chk("rand_amp_val", obs_amps[0], am);
            chk("rand_done", obs_done, 1);
        end

        // Async reset while dwelling.
        cfg(0, 100); cfg(1, 200); cfg(2, 50); cfg(3, 3); cfg(4, 9); cfg(5, 12);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        timed_out = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (set_phase_strobe_o) begin
                timed_out = 0;
                break;
            end
        end
        chk("rst_wait_phase", timed_out, 0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_enable", enable_o, 1);
        #2 rst_i = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_enable", enable_o, 0);
        chk("arst_ready", cfg_ready_o, 1);
        chk("arst_waveform", waveform_o, 0);
`ifdef SWEEP_STATUS_EN
        chk("arst_step_cnt", step_cnt_o, 0);
`endif
        @(negedge clk);
        rst_i = 1'b1;

        // Only START rewritten: defaults must give 250..255 step 1, AMPL 255, DWELL 1.
        cfg(0, 250);
        build(250, 255, 1, 0);
        sweep(1, 0, 0, 0);
        chk_loads("defaults");
        if (obs_amps.size() > 0) chk("defaults_amp_val", obs_amps[0], 255);
        chk("defaults_done", obs_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
